sar_adc_mc: RTL and testbench
=============================

# sar_adc_mc

Parametrised multi-channel successive-approximation ADC model in SV-RNM, written for both event-driven simulation and formal checking through `formal_rnm.sv`. It generalises the single-channel flash-style ADC model: configurable resolution and channel count, an explicit start/busy/done handshake, bit-serial SAR conversion over N clock cycles, and a per-channel result buffer. It sits between the analog front-end nets (real-valued) and the digital control logic that consumes codes.

## Interface
- `N`, 3: resolution in bits, from 2 to 12.
- `NCH`, 4: number of analog input channels, from 1 to 8.
- `CW`, `$clog2(NCH)` (minimum 1): channel-select width.
- `clk`  in  1: conversion clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: conversion request, sampled on `posedge clk`.
- `ch_sel`  in  CW: channel to convert, qualified by `start`.
- `VIN`  in  `real` [NCH]: analog inputs.
- `VSUP`  in  `real`: full-scale or supply voltage. Low reference is 0.0.
- `busy`  out  1: conversion in progress.
- `done`  out  1: one-cycle pulse when a result is written.
- `code`  out  N: result of the most recent conversion.
- `code_ch`  out  CW: channel of `code`.
- `code_all`  out  NCH*N: per-channel result buffer. Channel k occupies `[k*N +: N]`.
- `valid_mask`  out  NCH: bit k is set once channel k has been converted since reset.
- `oor`  out  1: out-of-range flag. Present only with `ADC_OOR_EN`.

## Operation
- FSM states are IDLE, CONVERT and DONE. Reset value is IDLE.
- Reset values: all outputs are 0, the hold registers are 0.0, and the bit index is N-1.
- IDLE: if `start` is 1 and `ch_sel` < NCH, then on the edge:
  - `vhold` is loaded with `VIN[ch_sel]`.
  - `shold` is loaded with `VSUP`.
  - `ch_sel` is latched.
  - The trial code is cleared and `bit_idx` is set to N-1.
  - The FSM moves to CONVERT.
- IDLE: if `ch_sel` >= NCH, `start` is ignored.
- CONVERT, one bit per edge:
  - `trial = acc | (1<<bit_idx)`.
  - The bit is kept if `vhold >= trial * shold / 2^N`, where the right-hand side is computed in `real`.
  - `bit_idx` decrements.
  - On the edge that resolves bit 0, the final code is written to `code`, `code_ch` and `code_all[ch]`, `valid_mask[ch]` is set, and the FSM moves to DONE.
- DONE: lasts one cycle, then the FSM returns to IDLE.
- `busy` is 1 in CONVERT and DONE. `done` is 1 only in DONE.
- `start` is ignored while `busy` is 1. No queueing.
- Range and clamping rules:
  - `vhold` < 0.0 gives code 0.
  - `vhold` >= `shold` gives all ones, including when VIN equals VSUP.
  - Otherwise the code is floor(vhold / (shold/2^N)).
  - `shold` <= 0.0 gives code 0.
- Inputs are sampled once per conversion. VIN and VSUP changes during CONVERT have no effect.
- Reset asserted mid-conversion aborts immediately. No result is written, and `code_all` and `valid_mask` are cleared.
- Result registers hold their value until the same channel is reconverted or reset is asserted.
- Formal property, always true: `done` implies `code == code_all[code_ch*N +: N]`.

## Timing
- Start is accepted at edge E0.
- `busy` is 1 from after E0 through after edge E(N+1).
- `done` and the new `code` are visible after edge EN.
- The FSM is back in IDLE after edge E(N+1).
- Minimum start-to-start spacing is N+2 cycles. With N=3 that is 5 cycles.
- `start` may be held high continuously. A new conversion is accepted on the first edge in IDLE.
- All state is updated on `posedge clk`. Reset is the only asynchronous path.

## Configuration
- `ADC_OOR_EN` defined:
  - Adds output `oor` and a hold bit set at sample time when `VIN[ch] < 0.0` or `VIN[ch] > VSUP`.
  - `oor` is valid with `done` and holds until the next `done`. Reset value is 0.
  - Adds the property: `done && oor` implies the code is 0 or all ones.
- `ADC_OOR_EN` undefined: there is no `oor` port and no flag logic. Clamping behaviour is identical.

## Test plan
All scenarios use N=3, NCH=4, VSUP=8.0 (delta 1.0).
- Conversion: VIN[1]=5.5, start with ch_sel=1 at E0. Required: `done` after E3, `code`=5, `code_ch`=1, `code_all[5:3]`=5, `valid_mask`=0010, `busy` low after E4.
- Boundaries: VIN=8.0 gives 7. VIN=0.999 gives 0. VIN=1.0 gives 1. VIN=9.0 gives 7 with `oor`=1. VIN=-1.0 gives 0 with `oor`=1, under `ADC_OOR_EN`.
- Buffering: convert ch0 at 3.2, then ch2 at 6.9. Required: `code_all`=12'b000_110_000_011 (ch3 ch2 ch1 ch0 = 0, 6, 0, 3), `valid_mask`=0101.
- Handshake: `start` pulsed at E1 and E2 during a conversion is ignored. `start` with `ch_sel`=3 after IDLE converts, completing after E(N+1) relative to that start. Changing VIN[0] from 2.0 to 7.0 mid-conversion still yields 2.
- Reset: `rst_n` low at E2 of a conversion. Required: `busy`, `done`, `code_all` and `valid_mask` are 0 immediately without waiting for a clock edge. The next conversion runs normally.
- Degenerate supply: VSUP=0.0, VIN=1.0. Required: code 0, and `oor`=1 under `ADC_OOR_EN`.

Source files
------------

// File: rtl/sar_adc_mc.sv
// Multi-channel bit-serial SAR ADC model with per-channel result buffer.
// Optional out-of-range flag output `oor` when ADC_OOR_EN is defined.
module sar_adc_mc #(
  parameter int N   = 3,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CW-1:0]   ch_sel,
  input  real             VIN [NCH],
  input  real             VSUP,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    code,
  output logic [CW-1:0]   code_ch,
  output logic [NCH*N-1:0] code_all,
`ifdef ADC_OOR_EN
  output logic [NCH-1:0]  valid_mask,
  output logic            oor
`else
  output logic [NCH-1:0]  valid_mask
`endif
);

  localparam int BW = $clog2(N);
  localparam real SCALE = real'(1 << N);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]    state;
  real           vhold;
  real           shold;
  logic [CW-1:0] ch_q;
  logic [N-1:0]  acc;
  logic [BW-1:0] bit_idx;
  logic [31:0]   ch_ext;
  logic          ch_ok;
  logic [N-1:0]  trial;
  logic [N-1:0]  acc_nxt;
  real           thr;
  logic          keep;

  assign ch_ext = 32'(ch_sel);
  assign ch_ok  = ch_ext < 32'(NCH);
  assign busy   = state != IDLE;
  assign done   = state == DONE;

  // A non-positive reference forces every trial to be rejected.
  always_comb begin
    trial   = acc | (N'(1) << bit_idx);
    thr     = real'(trial) * shold / SCALE;
    keep    = (shold > 0.0) && (vhold >= thr);
    acc_nxt = keep ? trial : acc;
  end

`ifdef ADC_OOR_EN
  logic oor_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_hold <= 1'b0;
      oor      <= 1'b0;
    end else begin
      if (state == IDLE && start && ch_ok)
        oor_hold <= (VIN[ch_sel] < 0.0) || (VIN[ch_sel] > VSUP);
      if (state == CONVERT && bit_idx == '0)
        oor <= oor_hold;
    end
  end

  always_comb begin
    if (rst_n && done && oor)
      assert (code == '0 || code == '1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vhold      <= 0.0;
      shold      <= 0.0;
      ch_q       <= '0;
      acc        <= '0;
      bit_idx    <= BW'(N - 1);
      code       <= '0;
      code_ch    <= '0;
      code_all   <= '0;
      valid_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && ch_ok) begin
            vhold   <= VIN[ch_sel];
            shold   <= VSUP;
            ch_q    <= ch_sel;
            acc     <= '0;
            bit_idx <= BW'(N - 1);
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          acc <= acc_nxt;
          if (bit_idx == '0) begin
            code                       <= acc_nxt;
            code_ch                    <= ch_q;
            code_all[int'(ch_q)*N +: N] <= acc_nxt;
            valid_mask[ch_q]           <= 1'b1;
            bit_idx                    <= BW'(N - 1);
            state                      <= DONE;
          end else begin
            bit_idx <= bit_idx - BW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    if (rst_n && done)
      assert (code == code_all[int'(code_ch)*N +: N]);
  end

endmodule

// File: tb/tb_sar_adc_mc.sv
// Directed bench for sar_adc_mc at N=3, NCH=4, VSUP=8.0.
// Checks oor as well when ADC_OOR_EN is defined.
module tb_sar_adc_mc;

  localparam int N   = 3;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   ch_sel = '0;
  real             vin [NCH];
  real             vsup = 8.0;
  logic            busy;
  logic            done;
  logic [N-1:0]    code;
  logic [CW-1:0]   code_ch;
  logic [NCH*N-1:0] code_all;
  logic [NCH-1:0]  valid_mask;
`ifdef ADC_OOR_EN
  logic            oor;
`endif

  int errors = 0;
  int checks = 0;

  sar_adc_mc #(.N(N), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel),
    .VIN(vin), .VSUP(vsup), .busy(busy), .done(done),
    .code(code), .code_ch(code_ch), .code_all(code_all),
`ifdef ADC_OOR_EN
    .valid_mask(valid_mask), .oor(oor)
`else
    .valid_mask(valid_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   ch;
    real  v;
    real  s;
    int   exp_code;
    logic exp_oor;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_oor(input string name, input logic exp);
`ifdef ADC_OOR_EN
    chk(name, int'(oor), int'(exp));
`endif
  endtask

  // Full conversion: start before E0, checks through E(N+1).
  task automatic run_conv(input int ch, input real v, input real s,
                          input int exp, input logic exp_oor);
    @(negedge clk);
    vin[ch] = v;
    vsup    = s;
    ch_sel  = CW'(ch);
    start   = 1'b1;
    @(posedge clk); #1;
    chk("busy_e0", int'(busy), 1);
    chk("done_e0", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (N - 1) @(posedge clk);
    #1 chk("done_early", int'(done), 0);
    @(posedge clk); #1;
    chk("done_en", int'(done), 1);
    chk("code", int'(code), exp);
    chk("code_ch", int'(code_ch), ch);
    chk("code_all_slice", int'(code_all[ch*N +: N]), exp);
    chk("valid_bit", int'(valid_mask[ch]), 1);
    chk_oor("oor", exp_oor);
    @(posedge clk); #1;
    chk("busy_end", int'(busy), 0);
    chk("done_end", int'(done), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [7];

  initial begin
    foreach (vin[i]) vin[i] = 0.0;
    vecs[0] = '{0, 8.0,   8.0, 7, 1'b0};
    vecs[1] = '{0, 0.999, 8.0, 0, 1'b0};
    vecs[2] = '{0, 1.0,   8.0, 1, 1'b0};
    vecs[3] = '{2, 9.0,   8.0, 7, 1'b1};
    vecs[4] = '{3, -1.0,  8.0, 0, 1'b1};
    vecs[5] = '{1, 3.2,   8.0, 3, 1'b0};
    vecs[6] = '{0, 4.0,   8.0, 4, 1'b0};

    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_code_ch", int'(code_ch), 0);
    chk("rst_code_all", int'(code_all), 0);
    chk("rst_valid", int'(valid_mask), 0);
    chk_oor("rst_oor", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv(1, 5.5, 8.0, 5, 1'b0);
    chk("code_all_first", int'(code_all), 12'o0050);
    chk("valid_first", int'(valid_mask), 4'b0010);

    for (int i = 0; i < 7; i++)
      run_conv(vecs[i].ch, vecs[i].v, vecs[i].s,
               vecs[i].exp_code, vecs[i].exp_oor);

    // Buffering after a clean reset.
    do_reset();
    chk("valid_cleared", int'(valid_mask), 0);
    run_conv(0, 3.2, 8.0, 3, 1'b0);
    run_conv(2, 6.9, 8.0, 6, 1'b0);
    chk("buf_code_all", int'(code_all), 12'b000_110_000_011);
    chk("buf_valid", int'(valid_mask), 4'b0101);

    // Handshake: starts during busy ignored, held start accepted in IDLE.
    @(negedge clk);
    vin[0] = 2.0;
    ch_sel = 2'd0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin[0] = 7.0;
    vin[3] = 6.0;
    ch_sel = 2'd3;
    repeat (2) @(posedge clk);
    #1 chk("hs_busy_e2", int'(busy), 1);
    @(posedge clk); #1;
    chk("hs_done_e3", int'(done), 1);
    chk("hs_code", int'(code), 2);
    chk("hs_code_ch", int'(code_ch), 0);
    @(posedge clk); #1;
    chk("hs_idle_e4", int'(busy), 0);
    @(posedge clk); #1;
    chk("hs_accept_e5", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("hs_done_e7", int'(done), 0);
    @(posedge clk); #1;
    chk("hs2_done", int'(done), 1);
    chk("hs2_code", int'(code), 6);
    chk("hs2_code_ch", int'(code_ch), 3);
    chk("hs2_slice", int'(code_all[9 +: 3]), 6);
    @(posedge clk); #1;
    chk("hs2_busy_end", int'(busy), 0);

    // Reset mid-conversion clears without a clock edge.
    @(negedge clk);
    vin[1] = 5.5;
    ch_sel = 2'd1;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_code_all", int'(code_all), 0);
    chk("mid_rst_valid", int'(valid_mask), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(2, 4.5, 8.0, 4, 1'b0);
    chk("post_rst_valid", int'(valid_mask), 4'b0100);

    // Degenerate reference.
    run_conv(1, 1.0, 0.0, 0, 1'b1);
    vsup = 8.0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
